uart_io_system: RTL and testbench

//  Top-level UART I/O subsystem: 8N1 receiver and transmitter plus a small

---
 rtl/uart_io_system_if.sv | 31 +++
 rtl/uart_io_system.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_uart_io_system.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_io_system_if.sv
// ---------------------------------------------------------------------------
// uart_io_system_if
//   Host-side bus of the UART I/O subsystem.
//   master : host / bench side (drives strobes and selectors, reads lectura)
//   slave  : uart_io_system side
//   Signals:
//     wr                host write strobe (edge detected in the slave)
//     rd                host read strobe  (edge detected in the slave)
//     selectorMuxIO     0 = auto-echo, 1 = host-driven transmit
//     selectorMuxMMIO   lectura source: 0 = RX data, 1 = status
//     selectorMuxALUCC  TX byte: 0 = unchanged, 1 = byte + 1 (mod 256)
//     lectura[7:0]      registered host read data
// ---------------------------------------------------------------------------
interface uart_io_system_if;
  logic       wr;
  logic       rd;
  logic       selectorMuxIO;
  logic       selectorMuxMMIO;
  logic       selectorMuxALUCC;
  logic [7:0] lectura;

  modport master (
    output wr, rd, selectorMuxIO, selectorMuxMMIO, selectorMuxALUCC,
    input  lectura
  );

  modport slave (
    input  wr, rd, selectorMuxIO, selectorMuxMMIO, selectorMuxALUCC,
    output lectura
  );
endinterface

// File: rtl/uart_io_system.sv
// ---------------------------------------------------------------------------
// uart_io_system
//   8N1 UART receiver + transmitter with a small memory-mapped register file.
//   Received bytes are either echoed automatically (selectorMuxIO=0) or sent
//   on a host write strobe (selectorMuxIO=1). The transmitted byte may be
//   incremented by one (selectorMuxALUCC=1).
//
//   Parameters:
//     clk_freq   system clock in Hz
//     baud_rate  serial bit rate; one bit = clk_freq/baud_rate clocks
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous reset, active low
//     rx         serial input, idle high (double-flop synchronised)
//     tx         serial output, idle high
//     host       uart_io_system_if.slave (wr, rd, selectors, lectura)
//   Configuration macro:
//     FRAMING_CHECK_EN  when defined, a byte whose stop bit is 0 is dropped
//                       (only frame_err is raised); otherwise it is stored.
//   Status register: {3'b0, zero_cc, frame_err, overrun, tx_busy, rx_avail}
// ---------------------------------------------------------------------------
module uart_io_system #(
  parameter int unsigned clk_freq  = 50_000_000,
  parameter int unsigned baud_rate = 9600
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic             tx,
  uart_io_system_if.slave  host
);

  localparam int unsigned BIT  = clk_freq / baud_rate;
  localparam int unsigned HALF = BIT / 2;
  localparam int unsigned CW   = (BIT > 1) ? $clog2(BIT) : 1;
  localparam logic [CW-1:0] CNT_BIT  = CW'(BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // input conditioning
  logic rx_s1, rx_s2, rx_prev;
  logic wr_q, rd_q;
  logic rx_fall, wr_rise, rd_rise;

  // receiver
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_stop_wait;
  logic          rx_tick;
  logic          rx_byte_done;
  logic          rx_frame_bad;
  logic          byte_store;

  // transmitter
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_tick;
  logic          tx_busy;
  logic          tx_go;
  logic [7:0]    tx_byte;

  // register file
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       overrun;
  logic       frame_err;
  logic       zero_cc;
  logic [7:0] lectura_q;
  logic [7:0] status;
  logic       rd_data;

  // -------------------------------------------------------------------------
  // Synchronisers and edge detectors
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      wr_q    <= host.wr;
      rd_q    <= host.rd;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;
  assign wr_rise = host.wr & ~wr_q;
  assign rd_rise = host.rd & ~rd_q;

  // -------------------------------------------------------------------------
  // Receiver FSM
  // -------------------------------------------------------------------------
  assign rx_tick = (rx_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        // A low stop bit parks the FSM here until the line is released, so a
        // held-low line produces exactly one frame event.
        if (rx_stop_wait) begin
          if (rx_s2) rx_next = RX_IDLE;
        end else if (rx_tick && rx_s2) begin
          rx_next = RX_IDLE;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_byte_done = 1'b0;
    rx_frame_bad = 1'b0;
    if (rx_state == RX_STOP && rx_tick && !rx_stop_wait) begin
      rx_byte_done = 1'b1;
      rx_frame_bad = ~rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_stop_wait <= 1'b0;
    end else begin
      unique case (rx_state)
        RX_IDLE: if (rx_fall) rx_cnt <= CNT_HALF;
        RX_START: begin
          if (rx_tick) begin
            rx_cnt <= CNT_BIT;
            rx_idx <= '0;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= CNT_BIT;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_STOP: if (!rx_tick) rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= '0;
      endcase
      rx_stop_wait <= (rx_next == RX_STOP) && (rx_stop_wait || rx_frame_bad);
    end
  end

`ifdef FRAMING_CHECK_EN
  assign byte_store = rx_byte_done & ~rx_frame_bad;
`else
  assign byte_store = rx_byte_done;
`endif

  // -------------------------------------------------------------------------
  // Transmitter FSM
  // -------------------------------------------------------------------------
  assign tx_tick = (tx_cnt == '0);
  assign tx_byte = host.selectorMuxALUCC ? (rx_data + 8'd1) : rx_data;
  assign tx_go   = (tx_state == TX_IDLE) &&
                   (host.selectorMuxIO ? wr_rise : rx_avail);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state <= TX_IDLE;
    else      tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (tx_go) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx      = 1'b1;
    tx_busy = 1'b1;
    unique case (tx_state)
      TX_IDLE: begin
        tx      = 1'b1;
        tx_busy = 1'b0;
      end
      TX_START: tx = 1'b0;
      TX_DATA:  tx = tx_shift[0];
      TX_STOP:  tx = 1'b1;
      default:  tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          if (tx_go) begin
            tx_cnt   <= CNT_BIT;
            tx_shift <= tx_byte;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_cnt <= CNT_BIT;
            tx_idx <= '0;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt   <= CNT_BIT;
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_idx   <= tx_idx + 3'd1;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_STOP: if (!tx_tick) tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Register file and host read port
  // -------------------------------------------------------------------------
  assign status  = {3'b000, zero_cc, frame_err, overrun, tx_busy, rx_avail};
  assign rd_data = rd_rise & ~host.selectorMuxMMIO;

  // Later assignments override earlier ones: a byte completing in the same
  // cycle as a data read or a TX launch keeps rx_avail set and is not an
  // overrun, since the previous byte was consumed in that very cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= '0;
      rx_avail  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      zero_cc   <= 1'b0;
      lectura_q <= '0;
    end else begin
      if (tx_go) begin
        zero_cc  <= (tx_byte == '0);
        rx_avail <= 1'b0;
      end
      if (rd_data) begin
        rx_avail  <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (rx_frame_bad) frame_err <= 1'b1;
      if (byte_store) begin
        rx_data  <= rx_shift;
        rx_avail <= 1'b1;
        if (rx_avail && !rd_data && !tx_go) overrun <= 1'b1;
      end
      if (rd_rise) lectura_q <= host.selectorMuxMMIO ? status : rx_data;
    end
  end

  assign host.lectura = lectura_q;

endmodule

// File: tb/tb_uart_io_system.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_io_system
//   Directed + randomised bench for uart_io_system. A behavioural model of
//   the register file predicts status/read data and the bytes that must
//   appear on tx; a line monitor decodes tx frames by bit-centre sampling.
// ---------------------------------------------------------------------------
module tb_uart_io_system;

  localparam int unsigned CLK_FREQ = 160;
  localparam int unsigned BAUD     = 10;
  localparam int unsigned BIT      = CLK_FREQ / BAUD;   // 16 clocks per bit
  localparam time         CP       = 10;
  // tx start must follow the rx stop-bit centre by at most sync latency + 2
  localparam time LAT_LO = (19 * BIT * CP) / 2;
  localparam time LAT_HI = LAT_LO + 6 * CP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  uart_io_system_if bus ();

  uart_io_system #(.clk_freq(CLK_FREQ), .baud_rate(BAUD)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .tx   (tx),
    .host (bus)
  );

  always #(CP/2) clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [7:0] m_data;
  bit         m_avail, m_ovr, m_ferr, m_zero;
  logic [7:0] exp_q[$];
  time        rx_t0;

  // monitor output
  logic [7:0] mon_b[$];
  bit         mon_s[$];
  time        mon_t[$];
  int         mon_low[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_status(input bit busy);
    return {3'b000, m_zero, m_ferr, m_ovr, busy, m_avail};
  endfunction

  task automatic model_reset();
    m_data = '0; m_avail = 0; m_ovr = 0; m_ferr = 0; m_zero = 0;
  endtask

  task automatic model_tx();
    logic [7:0] t;
    t = bus.selectorMuxALUCC ? m_data + 8'd1 : m_data;
    exp_q.push_back(t);
    m_zero  = (t == 8'h00);
    m_avail = 0;
  endtask

  task automatic model_rx(input logic [7:0] b, input bit stop_ok);
    bit store;
`ifdef FRAMING_CHECK_EN
    store = stop_ok;
`else
    store = 1'b1;
`endif
    if (!stop_ok) m_ferr = 1;
    if (store) begin
      if (m_avail) m_ovr = 1;
      m_avail = 1;
      m_data  = b;
    end
    if (!bus.selectorMuxIO && m_avail) model_tx();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_val);
    @(negedge clk);
    rx = 1'b0;
    rx_t0 = $time;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_val;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    model_rx(b, stop_val);
  endtask

  task automatic do_read(input bit mmio, input bit busy, input string tag);
    logic [7:0] e;
    @(negedge clk);
    bus.selectorMuxMMIO = mmio;
    @(negedge clk);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    if (mmio) e = m_status(busy);
    else begin
      e = m_data;
      m_avail = 0; m_ovr = 0; m_ferr = 0;
    end
    check(tag, bus.lectura, e);
  endtask

  task automatic pulse_wr();
    @(negedge clk);
    bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  task automatic expect_tx(input string tag, input bit chk_lat);
    logic [7:0] e;
    time        d;
    int         low;
    int         w;
    e = exp_q.pop_front();
    w = 0;
    while (mon_b.size() == 0 && w < int'(25 * BIT)) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_seen"}, (mon_b.size() != 0), 1);
    if (mon_b.size() != 0) begin
      check({tag, "_byte"}, mon_b.pop_front(), e);
      check({tag, "_stop"}, mon_s.pop_front(), 1);
      d   = mon_t.pop_front() - rx_t0;
      low = mon_low.pop_front();
      if (e[0]) check({tag, "_startw"}, low, BIT);
      if (chk_lat) begin
        checks++;
        assert (d >= LAT_LO && d <= LAT_HI) else begin
          failures++;
          $error("FAIL %s_latency observed=%0d ns expected=%0d..%0d ns", tag, d, LAT_LO, LAT_HI);
        end
      end
    end
    repeat (BIT) @(negedge clk);
  endtask

  // tx line monitor: bit-centre sampling from the falling start edge
  initial begin
    forever begin
      time        t0;
      int         low;
      bit         hi;
      logic [7:0] b;
      bit         s;
      @(negedge tx);
      t0 = $time; low = 0; hi = 0;
      for (int k = 0; k < int'(BIT) + 1; k++) begin
        @(negedge clk);
        if (!hi) begin
          if (tx === 1'b0) low++;
          else hi = 1;
        end
      end
      for (int i = 0; i < 9; i++) begin
        #(t0 + (BIT * (i + 1) + BIT / 2) * CP + CP / 2 - $time);
        if (i < 8) b[i] = tx;
        else       s = (tx === 1'b1);
      end
      mon_b.push_back(b);
      mon_s.push_back(s);
      mon_t.push_back(t0);
      mon_low.push_back(low);
    end
  end

  initial begin
    #(60000 * CP);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b, b2;
    bus.wr = 0; bus.rd = 0;
    bus.selectorMuxIO = 0; bus.selectorMuxMMIO = 0; bus.selectorMuxALUCC = 0;
    model_reset();
    #1 rst = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_lectura", bus.lectura, 8'h00);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    do_read(1, 0, "rst_status");

    // auto-echo
    send_frame(8'h41, 1);
    expect_tx("echo41", 1);
    do_read(1, 0, "echo_status");

    // increment path with wrap
    bus.selectorMuxALUCC = 1;
    send_frame(8'hFF, 1);
    expect_tx("aluFF", 1);
    do_read(1, 0, "alu_status");

    // random echo traffic
    for (int i = 0; i < 6; i++) begin
      bus.selectorMuxALUCC = 1'($urandom_range(0, 1));
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1);
      expect_tx($sformatf("rnd_echo%0d", i), 1);
    end
    do_read(1, 0, "rnd_echo_status");

    // host-driven mode
    bus.selectorMuxALUCC = 0;
    bus.selectorMuxIO    = 1;
    send_frame(8'h5A, 1);
    do_read(0, 0, "host_data");
    do_read(1, 0, "host_status");
    pulse_wr();
    model_tx();
    repeat (3 * BIT) @(negedge clk);
    do_read(1, 1, "busy_status");
    pulse_wr();                               // must be ignored while busy
    expect_tx("host_wr", 0);
    repeat (12 * BIT) @(negedge clk);
    check("busy_wr_ignored", mon_b.size(), 0);

    // overrun: two bytes, no read in between
    b  = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    send_frame(b, 1);
    send_frame(b2, 1);
    do_read(1, 0, "ovr_status");
    do_read(0, 0, "ovr_data");
    do_read(1, 0, "ovr_cleared");

    // break: line low for 20 bit times
    @(negedge clk) rx = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    rx = 1'b1;
    model_rx(8'h00, 0);
    repeat (12 * BIT) @(negedge clk);
    check("brk_no_tx", mon_b.size(), 0);
    do_read(1, 0, "brk_status");
    do_read(0, 0, "brk_data");
    do_read(1, 0, "brk_cleared");

    // single frame with a low stop bit
    send_frame(8'hA5, 0);
    do_read(1, 0, "badstop_status");
    do_read(0, 0, "badstop_data");

    // start-bit glitch shorter than half a bit
    @(negedge clk) rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    do_read(1, 0, "glitch_status");

    // random host-mode transmits
    for (int i = 0; i < 4; i++) begin
      bus.selectorMuxALUCC = 1'($urandom_range(0, 1));
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1);
      pulse_wr();
      model_tx();
      expect_tx($sformatf("rnd_host%0d", i), 0);
    end
    do_read(1, 0, "rnd_host_status");

    // reset in the middle of an echo transmission
    bus.selectorMuxALUCC = 0;
    bus.selectorMuxIO    = 0;
    send_frame(8'h33, 1);
    repeat (2 * BIT) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_lectura", bus.lectura, 8'h00);
    repeat (12 * BIT) @(negedge clk);
    mon_b.delete(); mon_s.delete(); mon_t.delete(); mon_low.delete();
    exp_q.delete();
    model_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    do_read(1, 0, "midrst_status");
    repeat (12 * BIT) @(negedge clk);
    check("midrst_no_tx", mon_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
